// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller: stage codes, ALU opcodes
// and the operand-steering select used between the FSM and its request mux.
package alu_seq_ctrl_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned STAGE_W = 3;

  localparam logic [STAGE_W-1:0] STAGE_IDLE      = 3'd0;
  localparam logic [STAGE_W-1:0] STAGE_EXECUTE   = 3'd1;
  localparam logic [STAGE_W-1:0] STAGE_PC_UPDATE = 3'd2;

  localparam logic [OP_W-1:0] ALU_OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] ALU_OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] ALU_OP_AND = 3'd2;
  localparam logic [OP_W-1:0] ALU_OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] ALU_OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] ALU_OP_SLT = 3'd5;
  localparam logic [OP_W-1:0] ALU_OP_SLL = 3'd6;
  localparam logic [OP_W-1:0] ALU_OP_SRL = 3'd7;

  typedef enum logic [1:0] {
    MUX_IDLE,
    MUX_EXEC,
    MUX_PC
  } mux_sel_e;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Decode-side issue bus plus shared-ALU request/response channel of the controller.
// master = the controller, slave = its environment (decode + ALU).
interface alu_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_seq_ctrl_pkg::*;

  logic                 start;
  logic [OP_W-1:0]      alu_operation;
  logic [WIDTH-1:0]     src_a;
  logic [WIDTH-1:0]     src_b;
  logic [WIDTH-1:0]     imm;
  logic                 use_imm;
  logic                 is_branch;

  logic [WIDTH-1:0]     alu_in0;
  logic [WIDTH-1:0]     alu_in1;
  logic [OP_W-1:0]      alu_op_select;
  logic                 alu_req_valid;
  logic                 alu_req_ready;
  logic                 alu_resp_valid;
  logic [WIDTH-1:0]     alu_result;

  logic [STAGE_W-1:0]   stage;
  logic                 busy;
  logic [WIDTH-1:0]     result_out;
  logic                 result_valid;
  logic [WIDTH-1:0]     pc_out;
  logic                 done;
  logic                 timeout_err;

  modport master (
    input  start, alu_operation, src_a, src_b, imm, use_imm, is_branch,
    input  alu_req_ready, alu_resp_valid, alu_result,
    output alu_in0, alu_in1, alu_op_select, alu_req_valid,
    output stage, busy, result_out, result_valid, pc_out, done, timeout_err
  );

  modport slave (
    output start, alu_operation, src_a, src_b, imm, use_imm, is_branch,
    output alu_req_ready, alu_resp_valid, alu_result,
    input  alu_in0, alu_in1, alu_op_select, alu_req_valid,
    input  stage, busy, result_out, result_valid, pc_out, done, timeout_err
  );

endinterface

// File: rtl/alu_seq_ctrl_alu_req_mux.sv
// Operand/opcode steering toward the shared ALU for the current sequencing phase.
module alu_req_mux
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PC_STEP = 1
) (
  input  mux_sel_e          sel_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [WIDTH-1:0]  imm_i,
  input  logic [WIDTH-1:0]  pc_i,
  input  logic              take_imm_i,
  output logic [WIDTH-1:0]  in0_o,
  output logic [WIDTH-1:0]  in1_o,
  output logic [OP_W-1:0]   op_o
);

  // Idle view doubles as the sequential PC-increment request.
  always_comb begin
    in0_o = pc_i;
    in1_o = WIDTH'(PC_STEP);
    op_o  = ALU_OP_ADD;
    case (sel_i)
      MUX_EXEC: begin
        in0_o = a_i;
        in1_o = b_i;
        op_o  = op_i;
      end
      MUX_PC: begin
        if (take_imm_i) in1_o = imm_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle instruction sequencer: execute then PC update, both through a shared
// ALU over valid/ready + response strobe, with branch-on-zero and response timeout.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC_REQ,
    S_EXEC_WAIT,
    S_PC_REQ,
    S_PC_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   imm_q, imm_d;
  logic               branch_q, branch_d;
  logic               zero_q, zero_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic               result_valid_q, result_valid_d;
  logic               done_q, done_d;
  logic               timeout_err_q, timeout_err_d;
  logic               busy_q, busy_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic               req_valid_q, req_valid_d;

  mux_sel_e           mux_sel;
  logic [WIDTH-1:0]   mux_in0;
  logic [WIDTH-1:0]   mux_in1;
  logic [OP_W-1:0]    mux_op;

  // Next-state, capture and timeout logic.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    imm_d          = imm_q;
    branch_d       = branch_q;
    zero_d         = zero_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    pc_d           = pc_q;
    result_valid_d = 1'b0;
    done_d         = 1'b0;
    timeout_err_d  = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d          = bus.alu_operation;
          a_d           = bus.src_a;
          b_d           = bus.use_imm ? bus.imm : bus.src_b;
          imm_d         = bus.imm;
          branch_d      = bus.is_branch;
          timeout_err_d = 1'b0;
          state_d       = S_EXEC_REQ;
        end
      end
      S_EXEC_REQ: begin
        if (bus.alu_req_ready) begin
          cnt_d   = CNT_W'(1);
          state_d = S_EXEC_WAIT;
        end
      end
      S_EXEC_WAIT: begin
        if (bus.alu_resp_valid) begin
          result_d       = bus.alu_result;
          result_valid_d = 1'b1;
          zero_d         = (bus.alu_result == '0);
          state_d        = S_PC_REQ;
        end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PC_REQ: begin
        if (bus.alu_req_ready) begin
          cnt_d   = CNT_W'(1);
          state_d = S_PC_WAIT;
        end
      end
      S_PC_WAIT: begin
        if (bus.alu_resp_valid) begin
          pc_d    = bus.alu_result;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    req_valid_d = (state_d == S_EXEC_REQ) || (state_d == S_PC_REQ);
    case (state_d)
      S_EXEC_REQ, S_EXEC_WAIT: stage_d = STAGE_EXECUTE;
      S_PC_REQ, S_PC_WAIT:     stage_d = STAGE_PC_UPDATE;
      default:                 stage_d = STAGE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= ALU_OP_ADD;
      a_q            <= '0;
      b_q            <= '0;
      imm_q          <= '0;
      branch_q       <= 1'b0;
      zero_q         <= 1'b0;
      cnt_q          <= '0;
      result_q       <= '0;
      pc_q           <= WIDTH'(RESET_PC);
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
      stage_q        <= STAGE_IDLE;
      req_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      imm_q          <= imm_d;
      branch_q       <= branch_d;
      zero_q         <= zero_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      pc_q           <= pc_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
      timeout_err_q  <= timeout_err_d;
      busy_q         <= busy_d;
      stage_q        <= stage_d;
      req_valid_q    <= req_valid_d;
    end
  end

  // Operands stay on the phase's values through the WAIT state as well.
  always_comb begin
    case (state_q)
      S_EXEC_REQ, S_EXEC_WAIT: mux_sel = MUX_EXEC;
      S_PC_REQ, S_PC_WAIT:     mux_sel = MUX_PC;
      default:                 mux_sel = MUX_IDLE;
    endcase
  end

  alu_req_mux #(
    .WIDTH   (WIDTH),
    .PC_STEP (PC_STEP)
  ) u_req_mux (
    .sel_i      (mux_sel),
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .imm_i      (imm_q),
    .pc_i       (pc_q),
    .take_imm_i (branch_q & zero_q),
    .in0_o      (mux_in0),
    .in1_o      (mux_in1),
    .op_o       (mux_op)
  );

  assign bus.alu_in0       = mux_in0;
  assign bus.alu_in1       = mux_in1;
  assign bus.alu_op_select = mux_op;
  assign bus.alu_req_valid = req_valid_q;
  assign bus.stage         = stage_q;
  assign bus.busy          = busy_q;
  assign bus.result_out    = result_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.pc_out        = pc_q;
  assign bus.done          = done_q;
  assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: the bench plays decode and ALU, and predicts every
// observable from an instruction-level model (result, PC, error flag).
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  localparam int unsigned W        = 32;
  localparam int unsigned TMO      = 15;
  localparam logic [31:0] RST_PC   = 32'h0;
  localparam logic [31:0] STEP_VAL = 32'h1;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  logic [31:0] pc_m;
  logic [31:0] res_m;
  logic        err_m;

  alu_seq_ctrl_if #(.WIDTH(W)) bus ();

  alu_seq_ctrl #(
    .WIDTH    (W),
    .PC_STEP  (1),
    .RESET_PC (0),
    .TIMEOUT  (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      ALU_OP_XOR: return a ^ b;
      ALU_OP_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_OP_SLL: return a << b[4:0];
      default:    return a >> b[4:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Bench acts as ALU: responds dly cycles after handshake; returns 1 if accepted.
  task automatic alu_wait(input int dly, input logic [31:0] val, output bit accepted);
    int last;
    last = (dly <= int'(TMO)) ? dly : int'(TMO);
    for (int d = 1; d <= last; d++) begin
      chk("wait_busy", 32'(bus.busy), 32'd1);
      chk("wait_no_req", 32'(bus.alu_req_valid), 32'd0);
      bus.alu_resp_valid = (d == dly);
      bus.alu_result     = (d == dly) ? val : 32'($urandom);
      step();
    end
    bus.alu_resp_valid = 1'b0;
    accepted = (dly <= int'(TMO));
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic ui, input logic br,
                           input int rdy_e, input int dly_e, input int rdy_p, input int dly_p,
                           input bit rst_in_pc);
    logic [31:0] bsel, r, pc_in1, pc_new;
    bit          acc;
    bsel = ui ? imm : b;
    r    = alu_ref(op, a, bsel);

    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_err", 32'(bus.timeout_err), 32'(err_m));
    chk("idle_in0", bus.alu_in0, pc_m);
    chk("idle_in1", bus.alu_in1, STEP_VAL);
    bus.start         = 1'b1;
    bus.alu_operation = op;
    bus.src_a         = a;
    bus.src_b         = b;
    bus.imm           = imm;
    bus.use_imm       = ui;
    bus.is_branch     = br;
    step();
    bus.start         = 1'b0;
    bus.alu_operation = 3'($urandom);
    bus.src_a         = $urandom;
    bus.src_b         = $urandom;
    bus.imm           = $urandom;
    bus.use_imm       = 1'($urandom);
    bus.is_branch     = 1'($urandom);
    err_m = 1'b0;
    chk("start_clears_err", 32'(bus.timeout_err), 32'd0);
    chk("exec_stage", 32'(bus.stage), 32'(STAGE_EXECUTE));

    for (int k = 0; k <= rdy_e; k++) begin
      chk("exec_valid", 32'(bus.alu_req_valid), 32'd1);
      chk("exec_in0", bus.alu_in0, a);
      chk("exec_in1", bus.alu_in1, bsel);
      chk("exec_op", 32'(bus.alu_op_select), 32'(op));
      bus.alu_req_ready  = (k == rdy_e);
      bus.alu_resp_valid = (k == rdy_e) ? 1'($urandom) : 1'b0;
      bus.alu_result     = $urandom;
      step();
    end
    bus.alu_req_ready  = 1'b0;
    bus.alu_resp_valid = 1'b0;

    alu_wait(dly_e, r, acc);
    if (!acc) begin
      err_m = 1'b1;
      chk("exec_tmo_err", 32'(bus.timeout_err), 32'd1);
      chk("exec_tmo_busy", 32'(bus.busy), 32'd0);
      chk("exec_tmo_pc", bus.pc_out, pc_m);
      chk("exec_tmo_res", bus.result_out, res_m);
      chk("exec_tmo_rv", 32'(bus.result_valid), 32'd0);
      return;
    end
    res_m = r;
    chk("result_valid", 32'(bus.result_valid), 32'd1);
    chk("result_out", bus.result_out, res_m);
    chk("pc_stage", 32'(bus.stage), 32'(STAGE_PC_UPDATE));

    pc_in1 = (br && r == 32'd0) ? imm : STEP_VAL;
    pc_new = pc_m + pc_in1;
    for (int k = 0; k <= rdy_p; k++) begin
      chk("pc_valid", 32'(bus.alu_req_valid), 32'd1);
      chk("pc_in0", bus.alu_in0, pc_m);
      chk("pc_in1", bus.alu_in1, pc_in1);
      chk("pc_op", 32'(bus.alu_op_select), 32'(ALU_OP_ADD));
      bus.alu_req_ready  = (k == rdy_p);
      bus.alu_resp_valid = (k == rdy_p) ? 1'($urandom) : 1'b0;
      bus.alu_result     = $urandom;
      step();
    end
    bus.alu_req_ready  = 1'b0;
    bus.alu_resp_valid = 1'b0;

    if (rst_in_pc) begin
      rst_n              = 1'b0;
      bus.alu_resp_valid = 1'b1;
      bus.alu_result     = 32'hDEAD_BEEF;
      step();
      pc_m  = RST_PC;
      res_m = 32'h0;
      err_m = 1'b0;
      chk("rst_pc", bus.pc_out, pc_m);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_stage", 32'(bus.stage), 32'(STAGE_IDLE));
      chk("rst_res", bus.result_out, res_m);
      chk("rst_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      step();
      bus.alu_resp_valid = 1'b0;
      chk("rst_stray_pc", bus.pc_out, pc_m);
      chk("rst_stray_busy", 32'(bus.busy), 32'd0);
      return;
    end

    alu_wait(dly_p, pc_new, acc);
    if (!acc) begin
      err_m = 1'b1;
      chk("pc_tmo_err", 32'(bus.timeout_err), 32'd1);
      chk("pc_tmo_busy", 32'(bus.busy), 32'd0);
      chk("pc_tmo_pc", bus.pc_out, pc_m);
      chk("pc_tmo_done", 32'(bus.done), 32'd0);
      chk("pc_tmo_res", bus.result_out, res_m);
      return;
    end
    pc_m = pc_new;
    chk("done", 32'(bus.done), 32'd1);
    chk("pc_out", bus.pc_out, pc_m);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_err", 32'(bus.timeout_err), 32'd0);
    chk("done_res", bus.result_out, res_m);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, imm;
    int          de, dp;
    n_vec = 0;
    n_bad = 0;
    pc_m  = RST_PC;
    res_m = 32'h0;
    err_m = 1'b0;
    rst_n = 1'b0;
    bus.start          = 1'b0;
    bus.alu_operation  = 3'd0;
    bus.src_a          = 32'h0;
    bus.src_b          = 32'h0;
    bus.imm            = 32'h0;
    bus.use_imm        = 1'b0;
    bus.is_branch      = 1'b0;
    bus.alu_req_ready  = 1'b0;
    bus.alu_resp_valid = 1'b0;
    bus.alu_result     = 32'h0;
    repeat (3) step();

    chk("reset_pc", bus.pc_out, RST_PC);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_req_valid", 32'(bus.alu_req_valid), 32'd0);
    chk("reset_res", bus.result_out, 32'h0);
    chk("reset_err", 32'(bus.timeout_err), 32'd0);
    chk("reset_stage", 32'(bus.stage), 32'(STAGE_IDLE));
    chk("reset_op", 32'(bus.alu_op_select), 32'(ALU_OP_ADD));
    rst_n = 1'b1;
    step();

    // Basic ADD 5+7, minimum latency.
    run_instr(ALU_OP_ADD, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 0, 1, 0, 1, 1'b0);
    // Walk PC to 4 (one of them via the immediate operand).
    run_instr(ALU_OP_OR, 32'h0F0, 32'h00F, 32'h1, 1'b1, 1'b0, 0, 1, 0, 1, 1'b0);
    run_instr(ALU_OP_XOR, 32'hAA, 32'h55, 32'h0, 1'b0, 1'b0, 1, 2, 0, 1, 1'b0);
    run_instr(ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0, 0, 1, 1, 2, 1'b0);
    // Taken branch from PC 4 by 0x10.
    run_instr(ALU_OP_SUB, 32'd9, 32'd9, 32'h10, 1'b0, 1'b1, 0, 1, 0, 1, 1'b0);
    // Negative taken branch back to 4, then a not-taken branch (result 3).
    run_instr(ALU_OP_SUB, 32'd3, 32'd3, 32'hFFFF_FFF0, 1'b0, 1'b1, 0, 1, 0, 1, 1'b0);
    run_instr(ALU_OP_SUB, 32'd5, 32'd2, 32'h10, 1'b0, 1'b1, 0, 1, 0, 1, 1'b0);
    // Backpressure on both requests and PC wrap through 0xFFFFFFFF.
    run_instr(ALU_OP_AND, 32'hF0, 32'h0F, 32'hFFFF_FFFA, 1'b0, 1'b1, 3, 1, 3, 1, 1'b0);
    run_instr(ALU_OP_ADD, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 2, 1, 3, 1, 1'b0);
    // Execute timeout, then the next start clears the flag; response at the boundary.
    run_instr(ALU_OP_ADD, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, 0, TMO + 1, 0, 1, 1'b0);
    run_instr(ALU_OP_SLL, 32'd1, 32'd4, 32'h0, 1'b0, 1'b0, 0, TMO, 0, TMO, 1'b0);
    // PC-phase timeout keeps the new result but not a new PC.
    run_instr(ALU_OP_SRL, 32'h80, 32'd3, 32'h0, 1'b0, 1'b0, 0, 1, 0, TMO + 1, 1'b0);
    // Reset during PC wait.
    run_instr(ALU_OP_ADD, 32'd2, 32'd2, 32'h0, 1'b0, 1'b0, 0, 1, 0, 2, 1'b1);

    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      if (b == a && $urandom_range(0, 1) == 1) op = ALU_OP_SUB;
      imm = $urandom;
      de  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 1, TMO + 1))
                                         : int'($urandom_range(1, 3));
      dp  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 1, TMO + 1))
                                         : int'($urandom_range(1, 3));
      run_instr(op, a, b, imm, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), de,
                int'($urandom_range(0, 3)), dp, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
